// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the P5 fetch sequencer.
package fetch_ctrl_pkg;

    typedef enum logic {
        FC_RUN   = 1'b0,
        FC_REDIR = 1'b1
    } fc_state_t;

    // One entry per control rule, in priority order.
    typedef enum logic [2:0] {
        R_RST,
        R_EXC,
        R_HOLD,
        R_WAIT,
        R_GO
    } fc_rule_t;

    localparam logic [31:0] IFID_NOP = 32'h0000_0000;

    function automatic fc_rule_t fc_rule(
        input logic rst,
        input logic exc,
        input logic hz,
        input logic rdy
    );
        if (rst)
            return R_RST;
        else if (exc)
            return R_EXC;
        else if (hz)
            return R_HOLD;
        else if (!rdy)
            return R_WAIT;
        else
            return R_GO;
    endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// Saturating count of consecutive fetch wait cycles with a sticky
// timeout flag.
module fetch_watchdog #(
    parameter int MAX_WAIT = 15,
    localparam int W = $clog2(MAX_WAIT + 1)
) (
    input  logic clk,
    input  logic Reset,
    input  logic inc,
    input  logic clr,
    input  logic hold,
    output logic timeout
);

    logic [W-1:0] cnt;
    logic [W-1:0] cnt_nxt;

    assign cnt_nxt = (cnt == W'(MAX_WAIT)) ? cnt : cnt + W'(1);

    always_ff @(posedge clk) begin
        if (Reset) begin
            cnt     <= '0;
            timeout <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !hold) begin
            cnt <= cnt_nxt;
            if (cnt_nxt == W'(MAX_WAIT))
                timeout <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// P5 fetch sequencer: redirects, IF/ID bubble control and a latched
// branch target for redirects that arrive while fetch is waiting.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        hz_stall,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    input  logic        exc_valid,
    input  logic [31:0] exc_target,
    input  logic        imem_ready,
    output logic        stall_pc,
    output logic        if_jump,
    output logic [31:0] next_pc,
    output logic        ifid_en,
    output logic        ifid_flush,
    output logic        redirect_pending,
    output logic        fetch_timeout,
    output logic        protocol_err
);

    fc_state_t   state;
    logic [31:0] pend_target;
    fc_rule_t    rule;
    logic        redir;

    assign rule  = fc_rule(Reset, exc_valid, hz_stall, imem_ready);
    assign redir = (state == FC_REDIR);
    assign redirect_pending = redir;

    always_comb begin
        stall_pc   = 1'b0;
        if_jump    = 1'b0;
        next_pc    = 32'h0;
        ifid_en    = 1'b1;
        ifid_flush = 1'b1;
        unique case (rule)
            R_RST: ;
            R_EXC: begin
                if_jump = 1'b1;
                next_pc = exc_target;
            end
            R_HOLD: begin
                stall_pc   = 1'b1;
                ifid_en    = 1'b0;
                ifid_flush = 1'b0;
            end
            R_WAIT: stall_pc = 1'b1;
            R_GO: begin
                ifid_flush = 1'b0;
                if (redir) begin
                    if_jump = 1'b1;
                    next_pc = pend_target;
                end else if (br_valid) begin
                    if_jump = 1'b1;
                    next_pc = br_target;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state        <= FC_RUN;
            pend_target  <= 32'h0;
            protocol_err <= 1'b0;
        end else begin
            case (rule)
                R_EXC: begin
                    state       <= FC_RUN;
                    pend_target <= 32'h0;
                end
                R_WAIT: begin
                    if (!redir && br_valid) begin
                        state       <= FC_REDIR;
                        pend_target <= br_target;
                    end
                end
                R_GO: begin
                    if (redir)
                        state <= FC_RUN;
                end
                default: ;
            endcase
            // A second branch cannot be queued behind a pending one.
            if ((rule == R_WAIT || rule == R_GO) && redir && br_valid)
                protocol_err <= 1'b1;
        end
    end

    fetch_watchdog #(
        .MAX_WAIT(MAX_WAIT)
    ) u_wdog (
        .clk    (clk),
        .Reset  (Reset),
        .inc    (rule == R_WAIT),
        .clr    (rule == R_EXC || rule == R_GO),
        .hold   (rule == R_HOLD),
        .timeout(fetch_timeout)
    );

endmodule
